// File: rtl/des_pkg.sv
// Shared types and constants for the deserializer link controller.
// The comma check lives here so the controller and any future aligner logic agree on it.
package des_pkg;

  typedef enum logic [1:0] {RST, HUNT, CHECK, LOCKED} des_link_state_e;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  function automatic logic is_comma(input logic [9:0] word);
    return (word == K28_5_RDN) || (word == K28_5_RDP);
  endfunction

endpackage

// File: rtl/des_err_window.sv
// Code-error monitor for the locked link: per-window error count with threshold pulse,
// plus a saturating total error count since the last clear.
module des_err_window #(
  parameter int ERR_THRESH = 3,
  parameter int ERR_WINDOW = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       word_valid_i,
  input  logic       code_err_i,
  output logic       thresh_hit_o,
  output logic [7:0] err_cnt_o
);

  localparam int WCW = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int ECW = $clog2(ERR_THRESH + 1);

  logic [WCW-1:0] win_cnt_q;
  logic [ECW-1:0] win_err_q;
  logic [ECW-1:0] win_base;
  logic [7:0]     err_cnt_q;
  logic           wrap;

  // On the wrapping word the old window is already gone, so its error starts the new one.
  assign wrap         = word_valid_i && (win_cnt_q == WCW'(ERR_WINDOW - 1));
  assign win_base     = wrap ? '0 : win_err_q;
  assign thresh_hit_o = word_valid_i && code_err_i && ((int'(win_base) + 1) >= ERR_THRESH);
  assign err_cnt_o    = err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
      win_err_q <= '0;
      err_cnt_q <= '0;
    end else if (clear_i) begin
      win_cnt_q <= '0;
      win_err_q <= '0;
      err_cnt_q <= '0;
    end else if (word_valid_i) begin
      win_cnt_q <= wrap ? '0 : win_cnt_q + 1'b1;
      if (code_err_i) begin
        win_err_q <= (int'(win_base) < ERR_THRESH) ? win_base + 1'b1 : win_base;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 1'b1;
      end else begin
        win_err_q <= win_base;
      end
    end
  end

endmodule

// File: rtl/des_link_ctrl.sv
// Receive link controller: FIFO reset sequencing, K28.5 comma lock acquisition,
// gated FIFO writes with error-driven loss of lock, and ready/valid FIFO draining.
module des_link_ctrl
  import des_pkg::*;
#(
  parameter int RST_CYCLES = 8,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_THRESH = 3,
  parameter int ERR_WINDOW = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       resync,
  input  logic       word_valid,
  input  logic [9:0] in_10b,
  input  logic       code_err,
  input  logic       full,
  input  logic       empty,
  input  logic       out_ready,
  output logic       wrst_n,
  output logic       rrst_n,
  output logic       w_en,
  output logic       r_en,
  output logic       out_valid,
  output logic       locked,
  output logic       overflow,
  output logic [7:0] err_cnt
);

  localparam int RCW = $clog2(RST_CYCLES);
  localparam int LCW = $clog2(LOCK_COUNT + 1);

  des_link_state_e state_q;
  logic [RCW-1:0]  rst_cnt_q;
  logic [LCW-1:0]  lock_cnt_q;
  logic            rst_rel_q;
  logic            locked_q;
  logic            overflow_q;
  logic            out_valid_q;

  logic comma, clean_comma, data_ok, in_locked, lock_last, lock_entry, thresh_hit;

  assign comma       = is_comma(in_10b);
  assign clean_comma = word_valid && comma && !code_err;
  assign data_ok     = word_valid && !comma && !code_err;
  assign in_locked   = (state_q == LOCKED);
  // HUNT always holds lock_cnt_q at zero, so LOCK_COUNT == 1 locks straight from HUNT.
  assign lock_last   = (lock_cnt_q == LCW'(LOCK_COUNT - 1));
  assign lock_entry  = ((state_q == HUNT) || (state_q == CHECK)) && clean_comma && lock_last;

  assign w_en      = in_locked && data_ok && !full;
  assign r_en      = (state_q != RST) && !empty && out_ready;
  assign wrst_n    = rst_rel_q;
  assign rrst_n    = rst_rel_q;
  assign locked    = locked_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

  des_err_window #(
    .ERR_THRESH(ERR_THRESH),
    .ERR_WINDOW(ERR_WINDOW)
  ) u_err_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (lock_entry),
    .word_valid_i(word_valid && in_locked),
    .code_err_i  (code_err),
    .thresh_hit_o(thresh_hit),
    .err_cnt_o   (err_cnt)
  );

  // NOTE: all state here uses non-blocking assignments so every branch sees the
  // pre-edge values; blocking assignments would make results depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST;
      rst_cnt_q   <= '0;
      lock_cnt_q  <= '0;
      rst_rel_q   <= 1'b0;
      locked_q    <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      overflow_q  <= in_locked && data_ok && full;
      out_valid_q <= r_en && !resync;
      if (resync) begin
        state_q    <= RST;
        rst_cnt_q  <= '0;
        lock_cnt_q <= '0;
        rst_rel_q  <= 1'b0;
        locked_q   <= 1'b0;
      end else begin
        case (state_q)
          RST: begin
            if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
              state_q   <= HUNT;
              rst_rel_q <= 1'b1;
            end else begin
              rst_cnt_q <= rst_cnt_q + 1'b1;
            end
          end
          HUNT, CHECK: begin
            if (clean_comma) begin
              if (lock_last) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                lock_cnt_q <= '0;
              end else begin
                state_q    <= CHECK;
                lock_cnt_q <= lock_cnt_q + 1'b1;
              end
            end else if (word_valid && (state_q == CHECK)) begin
              state_q    <= HUNT;
              lock_cnt_q <= '0;
            end
          end
          LOCKED: begin
            if (thresh_hit) begin
              state_q  <= HUNT;
              locked_q <= 1'b0;
            end
          end
          default: state_q <= RST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_des_link_ctrl.sv
// Directed bench for des_link_ctrl: reset sequencing, lock/failed lock, error windows,
// overflow, read handshake and resync.
module tb_des_link_ctrl;

  localparam logic [9:0] K_RDN = 10'b0011111010;
  localparam logic [9:0] K_RDP = 10'b1100000101;
  localparam logic [9:0] D     = 10'h155;

  logic       clk = 1'b0;
  logic       rst_n, resync, word_valid, code_err, full, empty, out_ready;
  logic [9:0] in_10b;
  logic       wrst_n, rrst_n, w_en, r_en, out_valid, locked, overflow;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  des_link_ctrl #(
    .RST_CYCLES(8), .LOCK_COUNT(4), .ERR_THRESH(3), .ERR_WINDOW(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .resync(resync), .word_valid(word_valid),
    .in_10b(in_10b), .code_err(code_err), .full(full), .empty(empty),
    .out_ready(out_ready), .wrst_n(wrst_n), .rrst_n(rrst_n), .w_en(w_en),
    .r_en(r_en), .out_valid(out_valid), .locked(locked), .overflow(overflow),
    .err_cnt(err_cnt)
  );

  task automatic send(input logic v, input logic [9:0] w, input logic e);
    @(negedge clk);
    word_valid = v;
    in_10b     = w;
    code_err   = e;
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send(1'b1, (i % 2 == 0) ? K_RDN : K_RDP, 1'b0);
    send(1'b0, 10'h000, 1'b0);
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (wrst_n !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0; resync = 1'b0; word_valid = 1'b0; in_10b = '0; code_err = 1'b0;
    full = 1'b0; empty = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    empty = 1'b0; out_ready = 1'b1; word_valid = 1'b1; in_10b = D;
    #1;
    checks++;
    if ({wrst_n, rrst_n, w_en, r_en, out_valid, locked, overflow, err_cnt} !== 15'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want all zero",
               {wrst_n, rrst_n, w_en, r_en, out_valid, locked, overflow, err_cnt});
    end
    word_valid = 1'b0;
    rst_n = 1'b1;
    wait_release(n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL reset_length: wrst_n low %0d cycles want 8", n); end
    checks++;
    if (rrst_n !== 1'b1) begin errors++; $display("FAIL rrst_release: rrst_n=%b want 1", rrst_n); end
    checks++;
    if (r_en !== 1'b1) begin errors++; $display("FAIL hunt_read: r_en=%b want 1", r_en); end
    empty = 1'b1; out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lock;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, (i % 2 == 0) ? K_RDN : K_RDP, 1'b0);
      #1;
      checks++;
      if (locked !== 1'b0 || w_en !== 1'b0) begin
        errors++;
        $display("FAIL lock_comma%0d: locked=%b w_en=%b want 0 0", i, locked, w_en);
      end
    end
    send(1'b1, D, 1'b0);
    #1;
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_rise: locked=%b want 1", locked); end
    checks++;
    if (w_en !== 1'b1) begin errors++; $display("FAIL lock_data_wen: w_en=%b want 1", w_en); end
    send(1'b0, D, 1'b0);
    #1;
    checks++;
    if (w_en !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL lock_idle: w_en=%b err_cnt=%0d want 0 0", w_en, err_cnt);
    end
  endtask

  task automatic test_overflow_read;
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_valid = 1'b0;
    full = 1'b1;
    send(1'b1, D, 1'b0);
    #1;
    checks++;
    if (w_en !== 1'b0) begin errors++; $display("FAIL full_wen: w_en=%b want 0", w_en); end
    send(1'b1, K_RDN, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse: overflow=%b want 1", overflow); end
    send(1'b0, D, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_comma: overflow=%b want 0", overflow); end
    full = 1'b0;
    empty = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== exp_valid) begin
        errors++;
        $display("FAIL out_valid_lag%0d: out_valid=%b want %b", i, out_valid, exp_valid);
      end
      out_ready = pat[i];
      #1;
      checks++;
      if (r_en !== pat[i]) begin errors++; $display("FAIL r_en_follow%0d: r_en=%b want %b", i, r_en, pat[i]); end
      exp_valid = pat[i];
    end
    empty = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (r_en !== 1'b0) begin errors++; $display("FAIL r_en_empty: r_en=%b want 0", r_en); end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err_loss;
    send(1'b1, D, 1'b1);
    #1;
    checks++;
    if (w_en !== 1'b0) begin errors++; $display("FAIL err_word_wen: w_en=%b want 0", w_en); end
    send(1'b1, D, 1'b0);
    send(1'b1, D, 1'b1);
    send(1'b1, D, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL err_two: locked=%b err_cnt=%0d want 1 2", locked, err_cnt);
    end
    send(1'b1, D, 1'b1);
    send(1'b0, D, 1'b0);
    checks++;
    if (locked !== 1'b0 || err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL err_loss: locked=%b err_cnt=%0d want 0 3", locked, err_cnt);
    end
    send_commas(4);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL relock_clear: locked=%b err_cnt=%0d want 1 0", locked, err_cnt);
    end
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 64; j++) send(1'b1, D, (j == 10) || (j == 20));
    send(1'b0, D, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'd6) begin
      errors++;
      $display("FAIL window_keep: locked=%b err_cnt=%0d want 1 6", locked, err_cnt);
    end
    // Error on the wrapping word carries into the next window: 1 + 2 more reaches 3.
    for (int j = 0; j < 64; j++) send(1'b1, D, (j == 50) || (j == 63));
    for (int j = 0; j <= 20; j++) begin
      send(1'b1, D, (j == 10) || (j == 20));
      if (j == 20) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL wrap_before: locked=%b want 1", locked); end
      end
    end
    send(1'b0, D, 1'b0);
    checks++;
    if (locked !== 1'b0 || err_cnt !== 8'd10) begin
      errors++;
      $display("FAIL wrap_carry: locked=%b err_cnt=%0d want 0 10", locked, err_cnt);
    end
  endtask

  task automatic test_failed_check;
    send(1'b1, K_RDN, 1'b0);
    send(1'b1, K_RDP, 1'b0);
    send(1'b1, D, 1'b0);
    #1;
    checks++;
    if (w_en !== 1'b0) begin errors++; $display("FAIL check_data_wen: w_en=%b want 0", w_en); end
    for (int i = 0; i < 4; i++) begin
      send(1'b1, (i % 2 == 0) ? K_RDN : K_RDP, 1'b0);
      checks++;
      if (locked !== 1'b0) begin errors++; $display("FAIL check_early%0d: locked=%b want 0", i, locked); end
    end
    send(1'b0, D, 1'b0);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL check_final: locked=%b want 1", locked); end
  endtask

  task automatic test_resync;
    int n;
    empty = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    resync = 1'b1;
    #1;
    checks++;
    if (r_en !== 1'b1) begin errors++; $display("FAIL resync_pre_ren: r_en=%b want 1", r_en); end
    @(negedge clk);
    resync = 1'b0;
    checks++;
    if ({locked, wrst_n, rrst_n, out_valid, r_en} !== 5'b0) begin
      errors++;
      $display("FAIL resync_rst: locked/wrst/rrst/out_valid/r_en=%b want 00000",
               {locked, wrst_n, rrst_n, out_valid, r_en});
    end
    empty = 1'b1; out_ready = 1'b0;
    wait_release(n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL resync_length: wrst_n low %0d cycles want 8", n); end
    send_commas(4);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL resync_relock: locked=%b want 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_overflow_read();
    test_err_loss();
    test_failed_check();
    test_resync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
